// File: rtl/seq_code_decoder.sv
// Decoder and order checker for the 4-bit shift-pattern traffic-light code.
// Define HOLD_TOL_EN to accept a repeated legal code as a hold while synced.
module seq_code_decoder #(
  parameter int LOCK_N = 3,
  parameter int ERR_W  = 8,
  parameter int CYC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       code_in,
  input  logic             code_valid,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             lock,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CYC_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_V = 3'(LOCK_N);

  state_t           state_q;
  logic [2:0]       prev_q;
  logic [2:0]       good_q;
  logic [2:0]       idx_q;
  logic             idx_valid_q;
  logic             lock_q;
  logic             seq_err_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [CYC_W-1:0] cyc_cnt_q;

  logic       legal;
  logic [2:0] dec_idx;
  logic [2:0] exp_idx;
  logic       is_exp;
  logic       is_hold;
  logic       err_ev;
  logic       cyc_ev;

  always_comb begin
    legal   = 1'b1;
    dec_idx = 3'd0;
    unique case (code_in)
      4'b0000: dec_idx = 3'd0;
      4'b0001: dec_idx = 3'd1;
      4'b0011: dec_idx = 3'd2;
      4'b0111: dec_idx = 3'd3;
      4'b1111: dec_idx = 3'd4;
      4'b1110: dec_idx = 3'd5;
      default: legal   = 1'b0;
    endcase
  end

  assign exp_idx = (prev_q == 3'd5) ? 3'd0 : prev_q + 3'd1;
  assign is_exp  = legal && (dec_idx == exp_idx);

`ifdef HOLD_TOL_EN
  assign is_hold = legal && (dec_idx == prev_q) && (state_q != HUNT);
`else
  assign is_hold = 1'b0;
`endif

  // Unexpected-but-legal codes only count as errors once locked.
  assign err_ev = code_valid &&
                  (!legal ||
                   (state_q == LOCKED && !is_exp && !is_hold));
  assign cyc_ev = code_valid && (state_q == LOCKED) &&
                  is_exp && (prev_q == 3'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      prev_q      <= 3'd0;
      good_q      <= 3'd0;
      idx_q       <= 3'd0;
      idx_valid_q <= 1'b0;
      lock_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
    end else begin
      idx_valid_q <= 1'b0;
      seq_err_q   <= err_ev;
      if (err_ev && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + 1'b1;
      if (cyc_ev)
        cyc_cnt_q <= cyc_cnt_q + 1'b1;
      if (code_valid) begin
        if (legal) begin
          idx_q       <= dec_idx;
          idx_valid_q <= 1'b1;
        end
        unique case (state_q)
          HUNT: begin
            if (legal) begin
              prev_q  <= dec_idx;
              good_q  <= 3'd0;
              state_q <= TRACK;
            end
          end
          TRACK: begin
            if (!legal) begin
              state_q <= HUNT;
            end else if (is_hold) begin
              state_q <= TRACK;
            end else if (is_exp) begin
              prev_q <= dec_idx;
              good_q <= good_q + 3'd1;
              if (good_q + 3'd1 == LOCK_V) begin
                state_q <= LOCKED;
                lock_q  <= 1'b1;
              end
            end else begin
              prev_q <= dec_idx;
              good_q <= 3'd0;
            end
          end
          LOCKED: begin
            if (!legal) begin
              state_q <= HUNT;
              lock_q  <= 1'b0;
            end else if (is_hold) begin
              state_q <= LOCKED;
            end else if (is_exp) begin
              prev_q <= dec_idx;
            end else begin
              prev_q  <= dec_idx;
              good_q  <= 3'd0;
              state_q <= TRACK;
              lock_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= HUNT;
            lock_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign lock      = lock_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;
  assign cyc_cnt   = cyc_cnt_q;

endmodule

// File: tb/tb_seq_code_decoder.sv
// Random plus directed stimulus for seq_code_decoder against a
// table-driven reference model of the code order rules.
module tb_seq_code_decoder;

  localparam int LOCK_N = 3;
  localparam int ERR_W  = 2;
  localparam int CYC_W  = 4;

`ifdef HOLD_TOL_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       code_in = 4'd0;
  logic             code_valid = 1'b0;
  logic [2:0]       idx;
  logic             idx_valid;
  logic             lock;
  logic             seq_err;
  logic [ERR_W-1:0] err_cnt;
  logic [CYC_W-1:0] cyc_cnt;

  seq_code_decoder #(
    .LOCK_N(LOCK_N),
    .ERR_W (ERR_W),
    .CYC_W (CYC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_valid(code_valid),
    .idx       (idx),
    .idx_valid (idx_valid),
    .lock      (lock),
    .seq_err   (seq_err),
    .err_cnt   (err_cnt),
    .cyc_cnt   (cyc_cnt)
  );

  always #5 clk = ~clk;

  logic [3:0] codes [6] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE};

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: position in the cycle plus a run of good steps.
  int m_idx, m_prev, m_run, m_errs, m_cycs;
  bit m_vld, m_err, m_synced, m_locked;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [3:0] c);
    for (int k = 0; k < 6; k++)
      if (codes[k] == c) return k;
    return -1;
  endfunction

  task automatic model(input bit r, input bit v, input logic [3:0] c);
    int k;
    m_vld = 0;
    m_err = 0;
    if (r) begin
      m_idx = 0; m_prev = 0; m_run = 0; m_errs = 0; m_cycs = 0;
      m_synced = 0; m_locked = 0;
      return;
    end
    if (!v) return;
    k = lookup(c);
    if (k < 0) begin
      m_err = 1; m_synced = 0; m_locked = 0;
    end else begin
      m_idx = k;
      m_vld = 1;
      if (!m_synced) begin
        m_synced = 1; m_prev = k; m_run = 0;
      end else if (HOLD && k == m_prev) begin
        m_run = m_run;
      end else if (k == (m_prev + 1) % 6) begin
        if (m_locked) begin
          if (m_prev == 5) m_cycs++;
        end else begin
          m_run++;
          if (m_run == LOCK_N) m_locked = 1;
        end
        m_prev = k;
      end else begin
        if (m_locked) m_err = 1;
        m_locked = 0; m_run = 0; m_prev = k;
      end
    end
    if (m_err && m_errs < (1 << ERR_W) - 1) m_errs++;
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] c);
    rst = r;
    code_valid = v;
    code_in = c;
    @(posedge clk);
    model(r, v, c);
    #1;
    chk("idx", int'(idx), m_idx);
    chk("idx_valid", int'(idx_valid), int'(m_vld));
    chk("lock", int'(lock), int'(m_locked));
    chk("seq_err", int'(seq_err), int'(m_err));
    chk("err_cnt", int'(err_cnt), m_errs);
    chk("cyc_cnt", int'(cyc_cnt), m_cycs % (1 << CYC_W));
  endtask

  task automatic feed(input int k);
    step(1'b0, 1'b1, codes[k]);
  endtask

  initial begin
    int r;
    logic [3:0] c;
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'h5);
    // Lock-up, wrap, then locked at idx 1.
    for (int k = 0; k < 6; k++) feed(k);
    feed(0); feed(1);
    // Illegal code while locked, then relock.
    step(1'b0, 1'b1, 4'h5);
    for (int k = 2; k < 6; k++) feed(k);
    feed(0); feed(1);
    // Legal skip while locked, then relock.
    feed(3); feed(4); feed(5); feed(0);
    feed(1); feed(2); feed(2);
    feed(3); feed(4); feed(5); feed(0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 4'($urandom));
    step(1'b1, 1'b1, 4'h1);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 4'h5 + 4'(i));
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      c = codes[(m_prev + 1) % 6];
      else if (r < 75) c = codes[m_prev];
      else if (r < 85) c = codes[$urandom_range(0, 5)];
      else             c = 4'($urandom);
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) != 0, c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
